bcd_down_timer: RTL

- Parametrised multi-digit BCD down-counter: the next generation of the single-digit modulo-10 down-counter in the timer subsystem.
- Counts a loaded BCD value down to zero on qualified tick strobes from the timebase prescaler.
- Supports one-shot and auto-reload modes, pause/resume and a terminal-count pulse.
- Drives the irrigation-interval and watering-duration displays and the valve sequencer.

---
 rtl/bcd_down_timer_if.sv | 27 ++
 rtl/bcd_down_timer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd_down_timer_if.sv
// Control and status bundle for the multi-digit BCD down-timer.
// The master side (tick source / controller) drives the commands and
// observes the count and status flags produced by the timer.
interface bcd_down_timer_if #(
   parameter int DIGITS = 2
);
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  start;
   logic                  stop;
   logic                  auto_reload;
   logic                  tick;
   logic [4*DIGITS-1:0]   q_bus;
   logic                  running;
   logic                  expired;
   logic                  done;

   modport master (
      output load, load_value, start, stop, auto_reload, tick,
      input  q_bus, running, expired, done
   );

   modport slave (
      input  load, load_value, start, stop, auto_reload, tick,
      output q_bus, running, expired, done
   );
endinterface

// File: rtl/bcd_down_timer.sv
// Parametrised multi-digit BCD down-counter with one-shot / auto-reload
// modes, pause/resume and a registered terminal-count pulse.
// Command priority within a cycle: load > stop > start > tick.
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input  logic              clock,
   input  logic              reset,
   bcd_down_timer_if.slave   bus
);

   localparam int W = 4 * DIGITS;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_EXPIRED = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W-1:0]    r_count;
   logic [W-1:0]    w_count_nxt;
   logic [W-1:0]    r_reload;
   logic [W-1:0]    w_reload_nxt;
   logic            r_done;
   logic            w_done_nxt;

   logic [W-1:0]    w_load_clamped;
   logic [W-1:0]    w_count_dec;
   logic            w_is_zero;
   logic            w_is_one;

   // Force every digit into 0..9 so q_bus never holds a non-BCD nibble.
   function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   d;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         r[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
      end
      return r;
   endfunction

   // Ripple-borrow BCD decrement: a zero digit that is borrowed from wraps to 9.
   function automatic logic [W-1:0] dec_bcd(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic [3:0]   d;
      logic         borrow;
      r      = '0;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         d = v[4*i +: 4];
         if (borrow) begin
            if (d == 4'd0) begin
               d = 4'd9;
            end else begin
               d      = d - 4'd1;
               borrow = 1'b0;
            end
         end
         r[4*i +: 4] = d;
      end
      return r;
   endfunction

   assign w_load_clamped = clamp_bcd(bus.load_value);
   assign w_count_dec    = dec_bcd(r_count);
   assign w_is_zero      = (r_count == '0);
   // BCD 1 and binary 1 share the same encoding.
   assign w_is_one       = (r_count == W'(1));

   // Next-state, next-count and terminal-count decode in priority order.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_done_nxt   = 1'b0;

      if (bus.load) begin
         w_count_nxt  = w_load_clamped;
         w_reload_nxt = w_load_clamped;
         w_state_nxt  = ST_IDLE;
      end else if (bus.stop && (r_state == ST_RUN)) begin
         w_state_nxt = ST_IDLE;
      end else if (bus.start && (r_state == ST_IDLE)) begin
         if (!w_is_zero) begin
            w_state_nxt = ST_RUN;
         end
      end else if (bus.start && (r_state == ST_EXPIRED)) begin
         if (r_reload != '0) begin
            w_count_nxt = r_reload;
            w_state_nxt = ST_RUN;
         end
      end else if (bus.tick && (r_state == ST_RUN)) begin
         if (w_is_zero) begin
            // Count sits at 0 only in auto-reload mode; this tick is the wrap.
            if (bus.auto_reload) begin
               w_count_nxt = r_reload;
               // A zero reload value makes every tick a terminal count.
               w_done_nxt  = (r_reload == '0);
            end else begin
               w_state_nxt = ST_EXPIRED;
            end
         end else begin
            w_count_nxt = w_count_dec;
            if (w_is_one) begin
               w_done_nxt = 1'b1;
               if (!bus.auto_reload) begin
                  w_state_nxt = ST_EXPIRED;
               end
            end
         end
      end
   end

   // State, count, reload and done registers with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_done   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Status flags decode directly from registered state: no input-to-output path.
   assign bus.q_bus   = r_count;
   assign bus.running = (r_state == ST_RUN);
   assign bus.expired = (r_state == ST_EXPIRED);
   assign bus.done    = r_done;

endmodule
